hazard_forward: RTL and testbench
=================================

# hazard_forward

Parametrised successor to the EX-stage forwarding unit. It resolves operands for NRD read ports in the execute stage by forwarding from MEM, from WB, and from a HIST_DEPTH-deep buffer of recently retired register writes. It detects load-use hazards, drives a pipeline stall with a per-episode cycle counter and a timeout pulse, and never forwards writes to x0.

## Interface
Parameters:
- XLEN, 32, data width
- XADDR, 5, register address width
- NRD, 2, number of EX read ports (≥1)
- HIST_DEPTH, 2, retired-write history entries (≥1)
- MAX_STALL, 16, consecutive stall cycles before timeout (≥1)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_rs_ex  in  NRD*XLEN  regfile-read operand values, port k at [k*XLEN +: XLEN]
- i_rs_addr_ex  in  NRD*XADDR  operand addresses, port k at [k*XADDR +: XADDR]
- i_rd_mem / i_rd_addr_mem / i_rd_mem_wr_en  in  XLEN / XADDR / 1  MEM-stage result, destination, write enable
- i_mem_is_load  in  1  MEM instruction is a load
- i_mem_data_valid  in  1  load data present on i_rd_mem this cycle
- i_rd_wb / i_rd_addr_wb / i_rd_wb_wr_en  in  XLEN / XADDR / 1  WB-stage result, destination, write enable
- i_wb_fire  in  1  WB instruction retires this cycle (one strobe per instruction)
- o_rs  out  NRD*XLEN  resolved operands
- o_fwd_sel  out  NRD*2  per-port source: 0 regfile, 1 MEM, 2 WB, 3 history
- o_stall  out  1  load-use stall request
- o_stall_timeout  out  1  one-cycle pulse when the stall episode reaches MAX_STALL
- o_stall_total  out  32  saturating count of stalled cycles since reset

## Operation
- Each port resolves independently. The first match in this priority list wins:
  1. MEM: addr≠0, addr==i_rd_addr_mem, i_rd_mem_wr_en, and !(i_mem_is_load && !i_mem_data_valid).
  2. WB: addr≠0, addr==i_rd_addr_wb, i_rd_wb_wr_en.
  3. History entry 0 (newest) through HIST_DEPTH-1: entry valid, addr≠0, addr matches.
  4. Otherwise i_rs_ex (sel 0).
- Port addr 0 always yields i_rs_ex with sel 0.
- Hazard: any port with addr≠0, addr==i_rd_addr_mem, i_rd_mem_wr_en, i_mem_is_load and !i_mem_data_valid.
  - o_stall=1.
  - That port's o_rs = i_rs_ex, sel 0. The value is don't-care while stalled.
- History push: on a clock edge with i_wb_fire && i_rd_wb_wr_en && i_rd_addr_wb≠0:
  - Entries shift toward index HIST_DEPTH-1; the oldest entry is dropped.
  - Entry 0 loads {valid=1, i_rd_addr_wb, i_rd_wb}.
  - Otherwise history holds.
  - A push whose address matches an existing entry does not invalidate that entry; priority resolves to the newest entry.
- Stall FSM, states RUN and STALL:
  - RUN→STALL when o_stall=1; the consecutive counter loads 1.
  - STALL→STALL while o_stall=1; the counter increments and saturates at MAX_STALL.
  - STALL→RUN when o_stall=0; the counter clears.
  - o_stall_timeout=1 for exactly one cycle, the cycle after the counter first reaches MAX_STALL within an episode. It does not repeat while the stall persists.
- o_stall_total increments on every clock edge with o_stall=1 and saturates at 2^32-1.

## Timing
- o_rs, o_fwd_sel and o_stall are combinational, with zero latency from inputs and the current history.
- A history push is visible to forwarding from the next cycle.
- o_stall_timeout and o_stall_total are registered.
- Reset (synchronous, i_rst=1 at the edge):
  - history valids=0, state=RUN, counters=0, o_stall_timeout=0.
  - While i_rst=1, o_stall is forced 0, and o_rs/o_fwd_sel resolve against MEM/WB only (history is empty).
- Reset mid-stall aborts the episode with no timeout pulse; o_stall_total returns to 0.
- Same edge as a push and a stall: both take effect. Stalling does not block history pushes.

## Test plan
- Port0 addr 5, MEM writes x5=0xAAAA, WB writes x5=0xBBBB -> o_rs[0]=0xAAAA, sel 1. Drop the MEM enable -> 0xBBBB, sel 2.
- Port1 addr 0, MEM and WB both target x0 with the enables high, i_rs_ex[1]=0x1234 -> o_rs[1]=0x1234, sel 0.
- Retire x7=0x11 then x7=0x22 (i_wb_fire), no MEM/WB match next cycle -> o_rs=0x22, sel 3. After HIST_DEPTH further retires to other registers, x7 falls back to sel 0.
- MEM load to x3, i_mem_data_valid=0 for 3 cycles, port0 addr 3 -> o_stall high for 3 cycles. Data valid in cycle 4 -> o_rs=load data, sel 1, o_stall=0, o_stall_total=3.
- With MAX_STALL=4, hold the load-use hazard for 10 cycles -> exactly one o_stall_timeout pulse, in the cycle after the 4th stall cycle; o_stall_total=10.
- Assert i_rst during cycle 2 of a stall -> next cycle: state RUN, o_stall_total=0, no timeout pulse, history empty.

Source files
------------

// File: rtl/hazard_forward.sv
// EX-stage operand forwarding from MEM, WB and a short retired-write history,
// with load-use stall detection, per-episode stall counter and timeout pulse.
module hazard_forward #(
    parameter int XLEN       = 32,
    parameter int XADDR      = 5,
    parameter int NRD        = 2,
    parameter int HIST_DEPTH = 2,
    parameter int MAX_STALL  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NRD*XLEN-1:0]   i_rs_ex,
    input  logic [NRD*XADDR-1:0]  i_rs_addr_ex,
    input  logic [XLEN-1:0]       i_rd_mem,
    input  logic [XADDR-1:0]      i_rd_addr_mem,
    input  logic                  i_rd_mem_wr_en,
    input  logic                  i_mem_is_load,
    input  logic                  i_mem_data_valid,
    input  logic [XLEN-1:0]       i_rd_wb,
    input  logic [XADDR-1:0]      i_rd_addr_wb,
    input  logic                  i_rd_wb_wr_en,
    input  logic                  i_wb_fire,
    output logic [NRD*XLEN-1:0]   o_rs,
    output logic [NRD*2-1:0]      o_fwd_sel,
    output logic                  o_stall,
    output logic                  o_stall_timeout,
    output logic [31:0]           o_stall_total
);

    localparam int CW = $clog2(MAX_STALL + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_STALL);

    typedef enum logic {RUN, STALL} state_t;

    state_t                r_state, w_state_nxt;
    logic [CW-1:0]         r_cnt, w_cnt_nxt;
    logic                  w_timeout_nxt;
    logic [HIST_DEPTH-1:0] r_hist_vld;
    logic [XADDR-1:0]      r_hist_addr [HIST_DEPTH];
    logic [XLEN-1:0]       r_hist_data [HIST_DEPTH];
    logic [NRD-1:0]        w_haz;
    logic                  w_push;
    logic                  w_load_pend;

    assign w_push      = i_wb_fire && i_rd_wb_wr_en && (i_rd_addr_wb != '0);
    assign w_load_pend = i_mem_is_load && !i_mem_data_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hist_vld <= '0;
        end else if (w_push) begin
            for (int unsigned i = 1; i < HIST_DEPTH; i++) begin
                r_hist_vld[i]  <= r_hist_vld[i-1];
                r_hist_addr[i] <= r_hist_addr[i-1];
                r_hist_data[i] <= r_hist_data[i-1];
            end
            r_hist_vld[0]  <= 1'b1;
            r_hist_addr[0] <= i_rd_addr_wb;
            r_hist_data[0] <= i_rd_wb;
        end
    end

    always_comb begin : resolve
        logic [XADDR-1:0] w_addr;
        logic             w_mem_hit;
        logic             w_found;
        o_rs      = i_rs_ex;
        o_fwd_sel = '0;
        w_haz     = '0;
        for (int unsigned k = 0; k < NRD; k++) begin
            w_addr    = i_rs_addr_ex[k*XADDR +: XADDR];
            w_mem_hit = (w_addr != '0) && (w_addr == i_rd_addr_mem) && i_rd_mem_wr_en;
            w_found   = 1'b0;
            // A pending load blocks WB/history fallback on this port: the operand must wait.
            if (w_addr == '0 || (w_mem_hit && w_load_pend)) begin
                w_haz[k] = w_mem_hit;
            end else if (w_mem_hit) begin
                o_rs[k*XLEN +: XLEN] = i_rd_mem;
                o_fwd_sel[k*2 +: 2]  = 2'd1;
            end else if ((w_addr == i_rd_addr_wb) && i_rd_wb_wr_en) begin
                o_rs[k*XLEN +: XLEN] = i_rd_wb;
                o_fwd_sel[k*2 +: 2]  = 2'd2;
            end else begin
                for (int unsigned j = 0; j < HIST_DEPTH; j++) begin
                    if (!w_found && !i_rst && r_hist_vld[j] && (w_addr == r_hist_addr[j])) begin
                        o_rs[k*XLEN +: XLEN] = r_hist_data[j];
                        o_fwd_sel[k*2 +: 2]  = 2'd3;
                        w_found              = 1'b1;
                    end
                end
            end
        end
    end

    assign o_stall = !i_rst && (|w_haz);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        case (r_state)
            RUN: begin
                if (o_stall) begin
                    w_state_nxt = STALL;
                    w_cnt_nxt   = CW'(1);
                end
            end
            STALL: begin
                if (o_stall) begin
                    w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CW'(1);
                end else begin
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = RUN;
        endcase
        w_timeout_nxt = o_stall && (w_cnt_nxt == CNT_MAX) && (r_cnt != CNT_MAX);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state         <= RUN;
            r_cnt           <= '0;
            o_stall_timeout <= 1'b0;
            o_stall_total   <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_cnt           <= w_cnt_nxt;
            o_stall_timeout <= w_timeout_nxt;
            if (o_stall && (o_stall_total != '1)) begin
                o_stall_total <= o_stall_total + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_forward.sv
// Directed-vector bench for hazard_forward (NRD=2, HIST_DEPTH=2, MAX_STALL=4).
module tb_hazard_forward;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] rs_ex;
    logic [9:0]  rs_addr_ex;
    logic [31:0] rd_mem, rd_wb;
    logic [4:0]  rd_addr_mem, rd_addr_wb;
    logic        rd_mem_wr_en, mem_is_load, mem_data_valid;
    logic        rd_wb_wr_en, wb_fire;
    logic [63:0] o_rs;
    logic [3:0]  o_fwd_sel;
    logic        o_stall, o_stall_timeout;
    logic [31:0] o_stall_total;

    int n_chk  = 0;
    int n_pass = 0;

    hazard_forward #(
        .XLEN(32), .XADDR(5), .NRD(2), .HIST_DEPTH(2), .MAX_STALL(4)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_rs_ex(rs_ex), .i_rs_addr_ex(rs_addr_ex),
        .i_rd_mem(rd_mem), .i_rd_addr_mem(rd_addr_mem), .i_rd_mem_wr_en(rd_mem_wr_en),
        .i_mem_is_load(mem_is_load), .i_mem_data_valid(mem_data_valid),
        .i_rd_wb(rd_wb), .i_rd_addr_wb(rd_addr_wb), .i_rd_wb_wr_en(rd_wb_wr_en),
        .i_wb_fire(wb_fire),
        .o_rs(o_rs), .o_fwd_sel(o_fwd_sel), .o_stall(o_stall),
        .o_stall_timeout(o_stall_timeout), .o_stall_total(o_stall_total)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic retire(input logic [4:0] a, input logic [31:0] d);
        rd_addr_wb = a; rd_wb = d; rd_wb_wr_en = 1'b1; wb_fire = 1'b1;
        step();
        rd_wb_wr_en = 1'b0; wb_fire = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1; rs_ex = '0; rs_addr_ex = '0;
        rd_mem = '0; rd_addr_mem = '0; rd_mem_wr_en = 1'b0;
        mem_is_load = 1'b0; mem_data_valid = 1'b0;
        rd_wb = '0; rd_addr_wb = '0; rd_wb_wr_en = 1'b0; wb_fire = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        #1;
        check("rst_total", o_stall_total, 32'd0);
        check("rst_timeout", {31'd0, o_stall_timeout}, 32'd0);
        check("rst_stall", {31'd0, o_stall}, 32'd0);
        check("rst_sel", {28'd0, o_fwd_sel}, 32'd0);

        // MEM beats WB, then WB when MEM disabled
        rs_addr_ex[4:0] = 5'd5; rs_ex[31:0] = 32'h5555;
        rd_addr_mem = 5'd5; rd_mem = 32'hAAAA; rd_mem_wr_en = 1'b1;
        rd_addr_wb = 5'd5; rd_wb = 32'hBBBB; rd_wb_wr_en = 1'b1;
        #1;
        check("mem_data", o_rs[31:0], 32'hAAAA);
        check("mem_sel", {30'd0, o_fwd_sel[1:0]}, 32'd1);
        rd_mem_wr_en = 1'b0;
        #1;
        check("wb_data", o_rs[31:0], 32'hBBBB);
        check("wb_sel", {30'd0, o_fwd_sel[1:0]}, 32'd2);

        // Load with data present forwards without stall
        rd_mem_wr_en = 1'b1; mem_is_load = 1'b1; mem_data_valid = 1'b1;
        #1;
        check("ldv_data", o_rs[31:0], 32'hAAAA);
        check("ldv_stall", {31'd0, o_stall}, 32'd0);
        mem_is_load = 1'b0; mem_data_valid = 1'b0;

        // x0 never forwarded
        rs_addr_ex[9:5] = 5'd0; rs_ex[63:32] = 32'h1234;
        rd_addr_mem = 5'd0; rd_addr_wb = 5'd0;
        #1;
        check("x0_data", o_rs[63:32], 32'h1234);
        check("x0_sel", {30'd0, o_fwd_sel[3:2]}, 32'd0);

        // History forwarding, newest wins, ages out after HIST_DEPTH pushes
        rd_mem_wr_en = 1'b0; rd_wb_wr_en = 1'b0;
        retire(5'd7, 32'h11);
        retire(5'd7, 32'h22);
        rs_addr_ex = {5'd7, 5'd7}; rs_ex = {32'h7777, 32'h7777};
        #1;
        check("hist_data0", o_rs[31:0], 32'h22);
        check("hist_sel0", {30'd0, o_fwd_sel[1:0]}, 32'd3);
        check("hist_data1", o_rs[63:32], 32'h22);
        retire(5'd8, 32'h1);
        check("hist_e1_data", o_rs[31:0], 32'h22);
        check("hist_e1_sel", {30'd0, o_fwd_sel[1:0]}, 32'd3);
        retire(5'd9, 32'h2);
        check("hist_aged_data", o_rs[31:0], 32'h7777);
        check("hist_aged_sel", {30'd0, o_fwd_sel[1:0]}, 32'd0);
        rs_addr_ex[9:5] = 5'd0;

        // Load-use stall for 3 cycles; WB match must not bypass the hazard
        do_reset();
        rs_addr_ex[4:0] = 5'd3; rs_ex[31:0] = 32'h3333;
        rd_addr_mem = 5'd3; rd_mem = 32'hDEAD; rd_mem_wr_en = 1'b1;
        mem_is_load = 1'b1; mem_data_valid = 1'b0;
        rd_addr_wb = 5'd3; rd_wb = 32'h4444; rd_wb_wr_en = 1'b1;
        #1;
        check("haz_sel", {30'd0, o_fwd_sel[1:0]}, 32'd0);
        check("haz_data", o_rs[31:0], 32'h3333);
        for (int i = 1; i <= 3; i++) begin
            check($sformatf("stall_c%0d", i), {31'd0, o_stall}, 32'd1);
            step();
        end
        mem_data_valid = 1'b1;
        #1;
        check("ld_done_stall", {31'd0, o_stall}, 32'd0);
        check("ld_done_data", o_rs[31:0], 32'hDEAD);
        check("ld_done_sel", {30'd0, o_fwd_sel[1:0]}, 32'd1);
        check("ld_done_total", o_stall_total, 32'd3);
        check("ld_done_timeout", {31'd0, o_stall_timeout}, 32'd0);
        rd_wb_wr_en = 1'b0;

        // 10-cycle stall with MAX_STALL=4: single timeout pulse in cycle 5
        do_reset();
        mem_data_valid = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            check($sformatf("timeout_c%0d", i), {31'd0, o_stall_timeout}, (i == 5) ? 32'd1 : 32'd0);
            if (i <= 10) step();
        end
        mem_data_valid = 1'b1;
        #1;
        check("long_total", o_stall_total, 32'd10);

        // Reset mid-stall
        retire(5'd9, 32'h99);
        rs_addr_ex[9:5] = 5'd9;
        #1;
        check("pre_rst_hist_sel", {30'd0, o_fwd_sel[3:2]}, 32'd3);
        mem_data_valid = 1'b0;
        #1;
        step();
        rst = 1'b1;
        #1;
        check("rst_forces_stall", {31'd0, o_stall}, 32'd0);
        check("rst_hides_hist", {30'd0, o_fwd_sel[3:2]}, 32'd0);
        step();
        rst = 1'b0;
        mem_is_load = 1'b0; rd_mem_wr_en = 1'b0;
        #1;
        check("post_rst_total", o_stall_total, 32'd0);
        check("post_rst_timeout", {31'd0, o_stall_timeout}, 32'd0);
        check("post_rst_hist", {30'd0, o_fwd_sel[3:2]}, 32'd0);
        step();
        check("post_rst_timeout2", {31'd0, o_stall_timeout}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
